vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Raster timing generator for the 640×480 @ 60 Hz display path. It drives the pixel coordinates `x`/`y` consumed by the text and graphics overlay blocks, along with the active-low sync pulses, the display-enable, and frame and line markers for the pad mux. It runs from the 25 MHz pixel clock, and every output is registered.

## Interface
- `H_DISPLAY`, 640: visible pixels per line
- `H_FRONT`, 16: horizontal front porch
- `H_SYNC`, 96: hsync width
- `H_BACK`, 48: horizontal back porch
- `V_DISPLAY`, 480: visible lines
- `V_FRONT`, 10: vertical front porch
- `V_SYNC`, 2: vsync width
- `V_BACK`, 33: vertical back porch

- `clk` input 1: pixel clock
- `rst_n` input 1: reset. Asynchronous, active-low.
- `ena` input 1: count enable. When low, the block holds its state.
- `x` output 10: horizontal position, 0..H_TOTAL-1
- `y` output 10: vertical position, 0..V_TOTAL-1
- `hsync` output 1: horizontal sync, active-low
- `vsync` output 1: vertical sync, active-low
- `display_on` output 1: high while `x` < H_DISPLAY and `y` < V_DISPLAY
- `line_start` output 1: one-cycle pulse when `x` wraps to 0
- `frame_start` output 1: one-cycle pulse when (`x`,`y`) wraps to (0,0)
- `frame_count` output 8: frame counter (see Configuration)

## Operation
- Derived constants:
  - H_TOTAL = sum of the four H params = 800.
  - V_TOTAL = sum of the four V params = 525.
- `x` increments every enabled cycle. At H_TOTAL-1 it wraps to 0 and `y` increments.
- `y` wraps from V_TOTAL-1 to 0 on the same cycle that `x` wraps.
- `hsync` is low for `x` in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1], i.e. [656,751].
- `vsync` is low for `y` in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1], i.e. [490,491]. It changes on the cycle `y` changes, aligned to `x`=0.
- `hsync`, `vsync` and `display_on` are registered. They are decoded from the next counter values, so each one corresponds to the `x`/`y` presented in the same cycle. There is no combinational path from any input to any output.
- `line_start` is high in the cycle where `x`=0, but only if that state was reached by a wrap.
- `frame_start` is high only in a cycle reached by the (H_TOTAL-1, V_TOTAL-1) → (0,0) wrap. It implies `line_start`.
- `ena` low:
  - `x`, `y`, `hsync`, `vsync`, `display_on` and `frame_count` hold.
  - `line_start` and `frame_start` are 0.
- Reset, asserted at any time including mid-line: all state goes immediately to its reset values, regardless of `ena`.

## Timing
- Reset values:
  - `x`=0, `y`=0
  - `hsync`=1, `vsync`=1
  - `display_on`=1
  - `line_start`=0, `frame_start`=0
  - `frame_count`=0
- After `rst_n` deasserts, the first enabled clock edge moves to `x`=1.
- No `line_start` or `frame_start` pulse occurs for the post-reset (0,0).
- Output latency is 0 cycles relative to the coordinate: every output describes the currently presented `x`/`y`.
- With `ena` held high:
  - One line is 800 cycles. One frame is 420 000 cycles.
  - `frame_start` pulses are exactly 420 000 cycles apart.

## Configuration
- `VGA_FRAME_CNT_EN` defined:
  - `frame_count` is an 8-bit register that increments in the same cycle `frame_start` is asserted.
  - It wraps from 255 to 0.
- Macro undefined:
  - `frame_count` is tied to 8'd0 and no counter flops are built.
  - The port list is unchanged.

## Structure
- Package `vga_timing_pkg` holds:
  - the default timing constants;
  - derived H_TOTAL/V_TOTAL;
  - sync start/end positions;
  - the coordinate width (10).
- Sub-module `vga_axis_counter` is used twice: horizontal, and vertical with its advance input driven by the horizontal wrap. Its parameters are TOTAL, SYNC_START and SYNC_END. It provides:
  - wrapping counter;
  - sync decode;
  - visible decode;
  - wrap strobe.

## Test plan
- Reset then run with `ena`=1 → `x` 0→799→0 with `line_start`=1 exactly at the wrap; `y` increments once per 800 cycles.
- Sample the `hsync` window → low for exactly 96 cycles, first low at `x`=656, last low at `x`=751. `vsync` is low only for `y`=490 and 491, i.e. 1600 cycles.
- Sample `display_on` → high at (639,479), low at (640,0) and at (0,480).
- Run two full frames → `frame_start` pulses 420 000 cycles apart. With `VGA_FRAME_CNT_EN`, `frame_count` reads 1 then 2. Without the macro it stays 0. Force 256 frames → 255 wraps to 0.
- Drop `ena` at `x`=799 for 10 cycles → all outputs hold and the pulses stay 0. On re-enable, the next cycle gives `x`=0, `line_start`=1.
- Assert `rst_n`=0 asynchronously at (400,200) → outputs go to their reset values before the next clock edge, and there is no `frame_start` after release.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 raster timing constants shared by the timing generator
package vga_timing_pkg;

  localparam int COORD_W = 10;

  localparam int H_DISPLAY = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_DISPLAY = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_DISPLAY + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: wrapping position counter with registered sync/visible decode
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL      = H_TOTAL,
  parameter int SYNC_START = H_SYNC_START,
  parameter int SYNC_END   = H_SYNC_END,
  parameter int VISIBLE    = H_DISPLAY
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               advance,
  output logic [COORD_W-1:0] count,
  output logic               sync_n,
  output logic               visible,
  output logic               wrap
);

  logic [COORD_W-1:0] count_next;
  logic               at_last;

  assign at_last = (count == COORD_W'(TOTAL - 1));
  assign wrap    = advance & at_last;

  always_comb begin
    count_next = count;
    if (advance) begin
      count_next = at_last ? '0 : count + 1'b1;
    end
  end

  // Decode from the next position so the registered flags line up with the registered count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      sync_n  <= 1'b1;
      visible <= 1'b1;
    end else begin
      count   <= count_next;
      sync_n  <= !((count_next >= COORD_W'(SYNC_START)) && (count_next <= COORD_W'(SYNC_END)));
      visible <= (count_next < COORD_W'(VISIBLE));
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator; VGA_FRAME_CNT_EN builds the 8-bit frame counter
module vga_timing_gen #(
  parameter int H_DISPLAY = vga_timing_pkg::H_DISPLAY,
  parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int H_BACK    = vga_timing_pkg::H_BACK,
  parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
  parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int V_BACK    = vga_timing_pkg::V_BACK
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               ena,
  output logic [vga_timing_pkg::COORD_W-1:0] x,
  output logic [vga_timing_pkg::COORD_W-1:0] y,
  output logic                               hsync,
  output logic                               vsync,
  output logic                               display_on,
  output logic                               line_start,
  output logic                               frame_start,
  output logic [7:0]                         frame_count
);

  localparam int H_TOT = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  logic h_wrap, v_wrap, h_vis, v_vis;

  vga_axis_counter #(
    .TOTAL      (H_TOT),
    .SYNC_START (H_DISPLAY + H_FRONT),
    .SYNC_END   (H_DISPLAY + H_FRONT + H_SYNC - 1),
    .VISIBLE    (H_DISPLAY)
  ) u_h (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (ena),
    .count   (x),
    .sync_n  (hsync),
    .visible (h_vis),
    .wrap    (h_wrap)
  );

  // Vertical axis steps only on the horizontal wrap, so its wrap already implies h_wrap.
  vga_axis_counter #(
    .TOTAL      (V_TOT),
    .SYNC_START (V_DISPLAY + V_FRONT),
    .SYNC_END   (V_DISPLAY + V_FRONT + V_SYNC - 1),
    .VISIBLE    (V_DISPLAY)
  ) u_v (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (h_wrap),
    .count   (y),
    .sync_n  (vsync),
    .visible (v_vis),
    .wrap    (v_wrap)
  );

  assign display_on = h_vis & v_vis;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= h_wrap;
      frame_start <= v_wrap;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [7:0] frame_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= 8'd0;
    end else if (v_wrap) begin
      frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end

  assign frame_count = frame_cnt_q;
`else
  assign frame_count = 8'd0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - bench for vga_timing_gen: full-size line timing plus a reduced geometry for frame timing
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena_f = 1'b0;
  logic ena_s = 1'b0;

  logic [9:0] x_f, y_f, x_s, y_s;
  logic hs_f, vs_f, do_f, ls_f, fs_f;
  logic hs_s, vs_s, do_s, ls_s, fs_s;
  logic [7:0] fc_f, fc_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_timing_gen dut_f (
    .clk(clk), .rst_n(rst_n), .ena(ena_f), .x(x_f), .y(y_f),
    .hsync(hs_f), .vsync(vs_f), .display_on(do_f), .line_start(ls_f),
    .frame_start(fs_f), .frame_count(fc_f)
  );

  // Reduced geometry: 15 x 12 total, hsync low x 10..12, vsync low y 8..9, frame = 180 cycles.
  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .ena(ena_s), .x(x_s), .y(y_s),
    .hsync(hs_s), .vsync(vs_s), .display_on(do_s), .line_start(ls_s),
    .frame_start(fs_s), .frame_count(fc_s)
  );

  typedef struct {
    int n;
    bit en;
    int ex;
    int ey;
    bit ehs;
    bit evs;
    bit edo;
    bit els;
    bit efs;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    ena_f = 1'b0;
    ena_s = 1'b0;
    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
  endtask

  initial begin
    int hs_low, hs_first, hs_last, ls_cnt, vs_low, last_fs, fs_idx, c;
    int ex, ey, efc;

    vecs[0]  = '{0,   1'b1, 0,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1,   1'b1, 1,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{638, 1'b1, 639, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1,   1'b1, 640, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{16,  1'b1, 656, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{95,  1'b1, 751, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1,   1'b1, 752, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{47,  1'b1, 799, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1,   1'b1, 0,   1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{1,   1'b1, 1,   1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{5,   1'b0, 1,   1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1,   1'b1, 2,   1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    // Table-driven walk through the first line of the full-size raster.
    @(negedge clk);
    do_reset();
    chk("reset_fc", int'(fc_f), 0);
    for (int i = 0; i < 12; i++) begin
      ena_f = vecs[i].en;
      step(vecs[i].n);
      chk($sformatf("v%0d_x", i), int'(x_f), vecs[i].ex);
      chk($sformatf("v%0d_y", i), int'(y_f), vecs[i].ey);
      chk($sformatf("v%0d_hsync", i), int'(hs_f), int'(vecs[i].ehs));
      chk($sformatf("v%0d_vsync", i), int'(vs_f), int'(vecs[i].evs));
      chk($sformatf("v%0d_display_on", i), int'(do_f), int'(vecs[i].edo));
      chk($sformatf("v%0d_line_start", i), int'(ls_f), int'(vecs[i].els));
      chk($sformatf("v%0d_frame_start", i), int'(fs_f), int'(vecs[i].efs));
    end

    // hsync window and line_start over one complete line.
    do_reset();
    ena_f = 1'b1;
    hs_low = 0; hs_first = -1; hs_last = -1; ls_cnt = 0;
    for (int i = 0; i < 800; i++) begin
      step(1);
      if (!hs_f) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(x_f);
        hs_last = int'(x_f);
      end
      if (ls_f) begin
        ls_cnt++;
        chk("ls_at_x0", int'(x_f), 0);
      end
    end
    chk("hsync_low_cycles", hs_low, 96);
    chk("hsync_first_x", hs_first, 656);
    chk("hsync_last_x", hs_last, 751);
    chk("line_start_count", ls_cnt, 1);
    chk("y_after_line", int'(y_f), 1);

    // Hold at x=799 for 10 cycles, then the wrap on re-enable.
    step(799);
    chk("pre_hold_x", int'(x_f), 799);
    ena_f = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("hold_x", int'(x_f), 799);
      chk("hold_y", int'(y_f), 1);
      chk("hold_hsync", int'(hs_f), 1);
      chk("hold_display_on", int'(do_f), 0);
      chk("hold_line_start", int'(ls_f), 0);
      chk("hold_frame_start", int'(fs_f), 0);
    end
    ena_f = 1'b1;
    step(1);
    chk("reen_x", int'(x_f), 0);
    chk("reen_y", int'(y_f), 2);
    chk("reen_line_start", int'(ls_f), 1);
    chk("reen_frame_start", int'(fs_f), 0);

    // Asynchronous reset mid-line: outputs must clear before the next clock edge.
    do_reset();
    ena_f = 1'b1;
    step(1200);
    chk("pre_rst_x", int'(x_f), 400);
    chk("pre_rst_y", int'(y_f), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_x", int'(x_f), 0);
    chk("arst_y", int'(y_f), 0);
    chk("arst_hsync", int'(hs_f), 1);
    chk("arst_vsync", int'(vs_f), 1);
    chk("arst_display_on", int'(do_f), 1);
    chk("arst_line_start", int'(ls_f), 0);
    chk("arst_frame_start", int'(fs_f), 0);
    chk("arst_fc", int'(fc_f), 0);
    step(2);
    rst_n = 1'b1;
    ls_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (ls_f || fs_f) ls_cnt++;
    end
    chk("post_rst_pulses", ls_cnt, 0);
    chk("post_rst_x", int'(x_f), 20);

    // Reduced geometry: every cycle for two frames, then frame pulses/count through 256 frames.
    do_reset();
    ena_s = 1'b1;
    vs_low = 0; last_fs = 0; fs_idx = 0;
    for (c = 1; c <= 256 * 180; c++) begin
      step(1);
      ex = c % 15;
      ey = (c / 15) % 12;
`ifdef VGA_FRAME_CNT_EN
      efc = (c / 180) % 256;
`else
      efc = 0;
`endif
      if (c <= 360) begin
        chk("s_x", int'(x_s), ex);
        chk("s_y", int'(y_s), ey);
        chk("s_hsync", int'(hs_s), (ex >= 10 && ex <= 12) ? 0 : 1);
        chk("s_vsync", int'(vs_s), (ey >= 8 && ey <= 9) ? 0 : 1);
        chk("s_display_on", int'(do_s), (ex < 8 && ey < 6) ? 1 : 0);
        chk("s_line_start", int'(ls_s), (ex == 0) ? 1 : 0);
        if (c <= 180 && !vs_s) vs_low++;
      end
      chk("s_frame_start", int'(fs_s), (c % 180 == 0) ? 1 : 0);
      if (fs_s) begin
        fs_idx++;
        chk("s_fs_spacing", c - last_fs, 180);
        chk("s_fs_implies_ls", int'(ls_s), 1);
        chk("s_fc_at_fs", int'(fc_s), efc);
        last_fs = c;
      end
    end
    chk("s_vsync_low_cycles", vs_low, 30);
    chk("s_frame_pulses", fs_idx, 256);
`ifdef VGA_FRAME_CNT_EN
    chk("s_fc_wrapped", int'(fc_s), 0);
`else
    chk("s_fc_tied", int'(fc_s), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
